// File: rtl/execute_stage_if.sv
// Execute stage bus: decode/execute register fields in,
// ALU result, condition and forwarded destination out.
interface execute_stage_if #(
  parameter int DATA_W = 64
);
  logic [2:0]        E_stat_i;
  logic [3:0]        E_icode_i;
  logic [3:0]        E_ifun_i;
  logic [DATA_W-1:0] E_valC_i;
  logic [DATA_W-1:0] E_valA_i;
  logic [DATA_W-1:0] E_valB_i;
  logic [3:0]        E_dstE_i;
  logic [2:0]        m_stat_i;
  logic [2:0]        W_stat_i;
  logic [DATA_W-1:0] e_valE_o;
  logic              e_Cnd_o;
  logic [3:0]        e_dstE_o;
  logic [DATA_W-1:0] e_valA_o;
  logic [2:0]        cc_o;

  modport master (
    output E_stat_i, E_icode_i, E_ifun_i,
    output E_valC_i, E_valA_i, E_valB_i,
    output E_dstE_i, m_stat_i, W_stat_i,
    input  e_valE_o, e_Cnd_o, e_dstE_o,
    input  e_valA_o, cc_o
  );

  modport slave (
    input  E_stat_i, E_icode_i, E_ifun_i,
    input  E_valC_i, E_valA_i, E_valB_i,
    input  E_dstE_i, m_stat_i, W_stat_i,
    output e_valE_o, e_Cnd_o, e_dstE_o,
    output e_valA_o, cc_o
  );
endinterface

// File: rtl/execute_stage.sv
// Y86-64 execute stage: ALU, condition evaluation and
// the architectural condition-code register.
module execute_stage #(
  parameter int         DATA_W = 64,
  parameter logic [2:0] CC_RST = 3'b100
) (
  input logic           clk_i,
  input logic           rst_i,
  execute_stage_if.slave e
);
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;
  localparam logic [3:0] ALUADD  = 4'h0;
  localparam logic [3:0] ALUSUB  = 4'h1;
  localparam logic [3:0] ALUAND  = 4'h2;
  localparam logic [3:0] ALUXOR  = 4'h3;
  localparam logic [3:0] RNONE   = 4'hF;
  localparam logic [2:0] SADR    = 3'd2;
  localparam logic [2:0] SINS    = 3'd3;
  localparam logic [2:0] SHLT    = 3'd4;
  localparam int         MSB     = DATA_W - 1;

  logic [3:0]        ic;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] res;
  logic [3:0]        fun;
  logic              of;
  logic              set_cc;
  logic              cnd;
  logic              lt;
  logic [2:0]        cc;

  assign ic = e.E_icode_i;

  function automatic logic bad(input logic [2:0] s);
    return (s == SADR) || (s == SINS) || (s == SHLT);
  endfunction

  always_comb begin
    alu_a = '0;
    unique case (1'b1)
      (ic == IRRMOVQ) || (ic == IOPQ):
        alu_a = e.E_valA_i;
      (ic == IIRMOVQ) || (ic == IRMMOVQ) ||
      (ic == IMRMOVQ):
        alu_a = e.E_valC_i;
      (ic == ICALL) || (ic == IPUSHQ):
        alu_a = '0 - DATA_W'(8);
      (ic == IRET) || (ic == IPOPQ):
        alu_a = DATA_W'(8);
      default:
        alu_a = '0;
    endcase
  end

  always_comb begin
    alu_b = '0;
    unique case (1'b1)
      (ic == IRMMOVQ) || (ic == IMRMOVQ) ||
      (ic == IOPQ) || (ic == ICALL) ||
      (ic == IPUSHQ) || (ic == IRET) ||
      (ic == IPOPQ):
        alu_b = e.E_valB_i;
      default:
        alu_b = '0;
    endcase
  end

  assign fun = (ic == IOPQ) ? e.E_ifun_i : ALUADD;

  always_comb begin
    res = '0;
    of  = 1'b0;
    unique case (fun)
      ALUADD: begin
        res = alu_b + alu_a;
        of  = (alu_a[MSB] == alu_b[MSB]) &&
              (res[MSB] != alu_a[MSB]);
      end
      ALUSUB: begin
        res = alu_b - alu_a;
        of  = (alu_a[MSB] != alu_b[MSB]) &&
              (res[MSB] != alu_b[MSB]);
      end
      ALUAND: res = alu_b & alu_a;
      ALUXOR: res = alu_b ^ alu_a;
      default: begin
        res = '0;
        of  = 1'b0;
      end
    endcase
  end

  // Faulting instructions further down must not see CC change.
  assign set_cc = (ic == IOPQ) &&
                  !bad(e.m_stat_i) &&
                  !bad(e.W_stat_i);

  always_ff @(posedge clk_i) begin
    if (rst_i)
      cc <= CC_RST;
    else if (set_cc)
      cc <= {(res == '0), res[MSB], of};
  end

  assign lt = cc[1] ^ cc[0];

  always_comb begin
    cnd = 1'b0;
    unique case (e.E_ifun_i)
      4'h0:    cnd = 1'b1;
      4'h1:    cnd = lt | cc[2];
      4'h2:    cnd = lt;
      4'h3:    cnd = cc[2];
      4'h4:    cnd = !cc[2];
      4'h5:    cnd = !lt;
      4'h6:    cnd = !lt && !cc[2];
      default: cnd = 1'b0;
    endcase
  end

  assign e.e_valE_o = res;
  assign e.e_Cnd_o  = cnd;
  assign e.e_dstE_o = ((ic == IRRMOVQ) && !cnd) ?
                      RNONE : e.E_dstE_i;
  assign e.e_valA_o = e.E_valA_i;
  assign e.cc_o     = cc;
endmodule
